// File: rtl/park_gate_ctrl.sv
// Parking-gate controller: two-part passcode entry, occupancy count, LED and 7-segment status.
// Defining PARK_LOCKOUT_EN builds the wrong-code LOCKOUT state; otherwise WRONG retries forever.
module park_gate_ctrl #(
    parameter int CAPACITY    = 9,
    parameter int CODE_W      = 2,
    parameter int PASS1       = 1,
    parameter int PASS2       = 2,
    parameter int WAIT_CYCLES = 4,
    parameter int MAX_TRIES   = 3,
    parameter int LOCK_CYCLES = 16,
    localparam int CNT_W      = $clog2(CAPACITY + 1)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              enter,
    input  logic              exit,
    input  logic              depart,
    input  logic [CODE_W-1:0] code1,
    input  logic [CODE_W-1:0] code2,
    output logic              GREEN_LED,
    output logic              RED_LED,
    output logic [6:0]        HEX_1,
    output logic [6:0]        HEX_2,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              locked
);

    localparam int TMR_MAX = (WAIT_CYCLES > LOCK_CYCLES) ? WAIT_CYCLES : LOCK_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int TRY_W   = $clog2(MAX_TRIES + 1);

    localparam logic [TMR_W-1:0] WAIT_LAST = TMR_W'(WAIT_CYCLES - 1);
    localparam logic [TRY_W-1:0] TRY_SAT   = {TRY_W{1'b1}};
    localparam logic [CNT_W-1:0] CAP_CNT   = CNT_W'(CAPACITY);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_N     = 7'b0101011;
    localparam logic [6:0] SEG_G     = 7'b1000010;
    localparam logic [6:0] SEG_O     = 7'b0100011;
    localparam logic [6:0] SEG_L     = 7'b1000111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CODE  = 3'd1,
        ST_WRONG = 3'd2,
`ifdef PARK_LOCKOUT_EN
        ST_LOCK  = 3'd4,
`endif
        ST_ADMIT = 3'd3
    } state_t;

    function automatic logic [6:0] digit_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Tens digit with a leading zero shown as blank.
    function automatic logic [6:0] tens_seg(input logic [6:0] v);
        logic [3:0] t;
        t = 4'(v / 7'd10);
        return (t == 4'd0) ? SEG_BLANK : digit_seg(t);
    endfunction

    function automatic logic [6:0] ones_seg(input logic [6:0] v);
        logic [3:0] o;
        o = 4'(v % 7'd10);
        return digit_seg(o);
    endfunction

    localparam logic [6:0] HEX1_RST = tens_seg(7'(CAPACITY));
    localparam logic [6:0] HEX2_RST = ones_seg(7'(CAPACITY));

    state_t             r_state;
    state_t             w_state_nxt;
    logic [TMR_W-1:0]   r_timer;
    logic [TMR_W-1:0]   w_timer_nxt;
    logic [TRY_W-1:0]   r_tries;
    logic [TRY_W-1:0]   w_tries_nxt;
    logic [TRY_W-1:0]   w_tries_inc;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_nxt;
    logic [6:0]         w_free_nxt;
    logic               w_inc;
    logic               w_dec;
    logic               w_match;
    logic               w_wait_done;
    logic               w_lock_now;
    logic               w_full_nxt;
    logic               r_green;
    logic               r_red;
    logic               r_full;
    logic               r_locked;
    logic [6:0]         r_hex1;
    logic [6:0]         r_hex2;
    logic               w_green_nxt;
    logic               w_red_nxt;
    logic               w_locked_nxt;
    logic [6:0]         w_hex1_nxt;
    logic [6:0]         w_hex2_nxt;

    assign w_match     = (code1 == CODE_W'(PASS1)) && (code2 == CODE_W'(PASS2));
    assign w_wait_done = (r_timer == WAIT_LAST);
    assign w_tries_inc = (r_tries == TRY_SAT) ? r_tries : r_tries + TRY_W'(1);
    assign w_inc       = (r_state == ST_ADMIT) && exit && (r_count != CAP_CNT);
    assign w_dec       = depart && (r_count != CNT_W'(0));
    assign w_count_nxt = r_count + CNT_W'(w_inc) - CNT_W'(w_dec);
    assign w_full_nxt  = (w_count_nxt == CAP_CNT);
    assign w_free_nxt  = 7'(CAPACITY) - 7'(w_count_nxt);

`ifdef PARK_LOCKOUT_EN
    assign w_lock_now  = (r_state == ST_WRONG) && (r_tries == TRY_W'(MAX_TRIES));
`else
    assign w_lock_now  = 1'b0;
`endif

    // Next-state, timer and tries-counter logic
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_tries_nxt = r_tries;
        case (r_state)
            ST_IDLE: begin
                w_tries_nxt = TRY_W'(0);
                w_timer_nxt = TMR_W'(0);
                if (enter && !r_full) begin
                    w_state_nxt = ST_CODE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CODE, ST_WRONG: begin
                if (w_lock_now) begin
                    w_timer_nxt = TMR_W'(0);
`ifdef PARK_LOCKOUT_EN
                    w_state_nxt = ST_LOCK;
`endif
                end else if (w_wait_done) begin
                    w_timer_nxt = TMR_W'(0);
                    if (w_match) begin
                        w_state_nxt = ST_ADMIT;
                    end else begin
                        w_state_nxt = ST_WRONG;
                        w_tries_nxt = w_tries_inc;
                    end
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end
            ST_ADMIT: begin
                w_tries_nxt = TRY_W'(0);
                w_timer_nxt = TMR_W'(0);
                if (!exit) begin
                    w_state_nxt = ST_ADMIT;
                end else if (enter && (w_count_nxt < CAP_CNT)) begin
                    w_state_nxt = ST_CODE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
`ifdef PARK_LOCKOUT_EN
            ST_LOCK: begin
                if (r_timer == TMR_W'(LOCK_CYCLES - 1)) begin
                    w_state_nxt = ST_IDLE;
                    w_timer_nxt = TMR_W'(0);
                    w_tries_nxt = TRY_W'(0);
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
                w_timer_nxt = TMR_W'(0);
                w_tries_nxt = TRY_W'(0);
            end
        endcase
    end

    // Output decode of the upcoming state so the status registers track it exactly
    always_comb begin
        w_green_nxt  = 1'b0;
        w_red_nxt    = 1'b0;
        w_locked_nxt = 1'b0;
        w_hex1_nxt   = SEG_BLANK;
        w_hex2_nxt   = SEG_BLANK;
        case (w_state_nxt)
            ST_IDLE: begin
                w_red_nxt  = w_full_nxt;
                w_hex1_nxt = tens_seg(w_free_nxt);
                w_hex2_nxt = ones_seg(w_free_nxt);
            end
            ST_CODE: begin
                w_red_nxt  = 1'b1;
                w_hex1_nxt = SEG_E;
                w_hex2_nxt = SEG_N;
            end
            ST_WRONG: begin
                w_red_nxt  = (r_state == ST_WRONG) ? ~r_red : 1'b1;
                w_hex1_nxt = SEG_E;
                w_hex2_nxt = SEG_E;
            end
            ST_ADMIT: begin
                w_green_nxt = 1'b1;
                w_hex1_nxt  = SEG_G;
                w_hex2_nxt  = SEG_O;
            end
`ifdef PARK_LOCKOUT_EN
            ST_LOCK: begin
                w_red_nxt    = 1'b1;
                w_locked_nxt = 1'b1;
                w_hex1_nxt   = SEG_L;
                w_hex2_nxt   = SEG_L;
            end
`endif
            default: begin
                w_red_nxt  = 1'b1;
                w_hex1_nxt = SEG_BLANK;
                w_hex2_nxt = SEG_BLANK;
            end
        endcase
    end

    // Control state, timers and occupancy
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_timer <= TMR_W'(0);
            r_tries <= TRY_W'(0);
            r_count <= CNT_W'(0);
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_tries <= w_tries_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Registered status outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_green  <= 1'b0;
            r_red    <= 1'b0;
            r_full   <= 1'b0;
            r_locked <= 1'b0;
            r_hex1   <= HEX1_RST;
            r_hex2   <= HEX2_RST;
        end else begin
            r_green  <= w_green_nxt;
            r_red    <= w_red_nxt;
            r_full   <= w_full_nxt;
            r_locked <= w_locked_nxt;
            r_hex1   <= w_hex1_nxt;
            r_hex2   <= w_hex2_nxt;
        end
    end

    assign GREEN_LED = r_green;
    assign RED_LED   = r_red;
    assign HEX_1     = r_hex1;
    assign HEX_2     = r_hex2;
    assign count     = r_count;
    assign full      = r_full;
    assign locked    = r_locked;

endmodule

// File: doc/park_gate_ctrl.md
# park_gate_ctrl

Parametrised parking-gate controller: a car at the entry sensor is asked for a two-part passcode, admitted on a match, and counted into an occupancy register. It refuses entry when the lot is full, tracks departures, and shows free spaces or gate status on two seven-segment digits. This is the next-generation gate block, adding capacity tracking, configurable code width and wait time, tailgate handling, and an optional wrong-code lockout.

## Interface
- CAPACITY, 9: number of spaces; legal range 1..99.
- CODE_W, 2: width of each code half.
- PASS1, 1: required value on code1.
- PASS2, 2: required value on code2.
- WAIT_CYCLES, 4: cycles allowed for code entry before sampling; ≥1.
- MAX_TRIES, 3: consecutive wrong samples before lockout; ≥1.
- LOCK_CYCLES, 16: lockout duration; ≥1.
- Derived CNT_W = $clog2(CAPACITY+1).

- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enter  in  1  entry sensor, car present at gate.
- exit  in  1  gate-passage sensor, admitted car has passed.
- depart  in  1  one-cycle pulse, a car left the lot.
- code1  in  CODE_W  first code half.
- code2  in  CODE_W  second code half.
- GREEN_LED  out  1  gate open.
- RED_LED  out  1  gate closed, lot full, or wrong code (blinking).
- HEX_1  out  7  left digit, active-low, bit order {g,f,e,d,c,b,a}.
- HEX_2  out  7  right digit, same encoding.
- count  out  CNT_W  current occupancy.
- full  out  1  count == CAPACITY.
- locked  out  1  controller is in LOCKOUT.

## Operation
- States: IDLE, WAIT_CODE, WRONG, ADMIT, LOCKOUT.
- IDLE: enter && !full → WAIT_CODE. If enter && full, stay in IDLE. The tries counter is cleared.
- WAIT_CODE: the wait counter runs 0..WAIT_CYCLES-1. On the edge where it equals WAIT_CYCLES-1, code1/code2 are sampled:
  - match (code1==PASS1 && code2==PASS2) → ADMIT;
  - otherwise tries++ → WRONG.
- enter is ignored outside IDLE and ADMIT.
- WRONG: if tries == MAX_TRIES → LOCKOUT (macro on). Otherwise the wait counter restarts and codes are resampled after WAIT_CYCLES: a match goes to ADMIT; a mismatch does tries++ and stays in WRONG.
- ADMIT: tries is cleared. On exit:
  - count++;
  - if enter is also high and the new count < CAPACITY → WAIT_CODE (tailgate, the next car must enter its own code);
  - otherwise → IDLE.
- LOCKOUT: a counter runs LOCK_CYCLES cycles, then → IDLE with tries cleared. All inputs except depart are ignored.
- depart: count-- if count > 0, in any state; when count == 0 it is ignored.
- An admit increment and a depart decrement in the same cycle leave count unchanged.
- count never exceeds CAPACITY.
- LEDs:
  - IDLE: GREEN=0, RED=full.
  - WAIT_CODE: GREEN=0, RED=1.
  - WRONG: GREEN=0, RED toggles every cycle, starting at 1 on entry.
  - ADMIT: GREEN=1, RED=0.
  - LOCKOUT: GREEN=0, RED=1.
- HEX_1/HEX_2 by state:
  - IDLE: free = CAPACITY−count in decimal, tens on HEX_1, ones on HEX_2; a leading zero is blanked.
  - WAIT_CODE: "En".
  - WRONG: "EE".
  - ADMIT: "Go".
  - LOCKOUT: "LL".
- Digit patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Letter patterns: E=0000110, n=0101011, G=1000010, o=0100011, L=1000111, blank=1111111.

## Timing
- Moore machine: all outputs decode registered state and counters only, and change on the edge after the triggering input is sampled.
- enter sampled at edge k → WAIT_CODE visible after k. Codes are sampled at edge k+WAIT_CYCLES, and ADMIT/WRONG is visible after that edge.
- exit sampled at edge j → count updated and next state visible after j.
- Reset (async, any time, including mid-transaction) forces:
  - state IDLE, count 0, tries 0, all timers 0;
  - GREEN=0, RED=0, full=0, locked=0;
  - HEX shows CAPACITY.

## Configuration
- PARK_LOCKOUT_EN defined: reaching MAX_TRIES in WRONG enters LOCKOUT for LOCK_CYCLES cycles with locked=1.
- PARK_LOCKOUT_EN undefined:
  - LOCKOUT state, lock counter and tries compare are not built;
  - WRONG retries indefinitely;
  - locked is tied to 0.

## Test plan
- Defaults; reset, enter at cycle 6, code1=1/code2=2 → ADMIT visible 4 cycles after WAIT_CODE entry, GREEN=1, HEX="Go"; exit → count=1, IDLE, HEX=blank,"8".
- Wrong codes (0,0) held with macro on → WRONG, RED blinking, then LOCKOUT after the third sample with locked=1 for 16 cycles, then IDLE; with macro off, locked stays 0 and a later correct code → ADMIT.
- CAPACITY=2: admit two cars → full=1, RED=1 in IDLE, HEX=blank,"0"; enter ignored; depart pulse → count=1, full=0, next enter accepted.
- Tailgate: in ADMIT assert exit and enter together with count=0, CAPACITY=9 → count=1, state WAIT_CODE, HEX="En".
- Simultaneous exit and depart in ADMIT with count=3 → count stays 3; depart at count=0 → count stays 0.
- Assert reset_n=0 mid-WAIT_CODE and mid-ADMIT → asynchronous return to IDLE, count=0, LEDs off, HEX shows CAPACITY.
